// File: rtl/alu_share_arbiter_if.sv
// Requester-side and ALU-side signal bundle for the shared-ALU arbiter.
// The arbiter uses the slave view; requesters and the ALU use the master view.
interface alu_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_busA;
    logic [NREQ*WIDTH-1:0] req_busB;
    logic [NREQ*OPW-1:0]   req_op;

    logic [WIDTH-1:0]      alu_busA;
    logic [WIDTH-1:0]      alu_busB;
    logic [OPW-1:0]        alu_op;
    logic [WIDTH-1:0]      alu_dataOut;
    logic [3:0]            alu_flags;

    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [3:0]            rsp_flags;

    modport master (
        output req_valid, req_busA, req_busB, req_op, rsp_ready, alu_dataOut, alu_flags,
        input  req_ready, alu_busA, alu_busB, alu_op, rsp_valid, rsp_data, rsp_flags
    );

    modport slave (
        input  req_valid, req_busA, req_busB, req_op, rsp_ready, alu_dataOut, alu_flags,
        output req_ready, alu_busA, alu_busB, alu_op, rsp_valid, rsp_data, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters: grant, drive
// registered operands, wait ALU_LAT cycles, capture result, hand it back.
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic                 busy
);
    localparam int IW = $clog2(NREQ);
    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t          state, stateNext;
    logic [IW-1:0]   rrPtr, grantIdx, pickIdx;
    logic [LW-1:0]   latCnt;
    logic [IW:0]     pickSum;
    logic [NREQ-1:0] reqRot;
    logic            anyValid, latDone, rspDone;

    // Rotate the request vector so bit 0 is the rrPtr slot; the lowest set bit wins.
    always_comb begin
        reqRot   = NREQ'({bus.req_valid, bus.req_valid} >> rrPtr);
        anyValid = |bus.req_valid;
        pickSum  = {1'b0, rrPtr};
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (reqRot[k]) pickSum = {1'b0, rrPtr} + (IW+1)'(k);
        end
        pickIdx = (pickSum >= (IW+1)'(NREQ)) ? IW'(pickSum - (IW+1)'(NREQ)) : IW'(pickSum);
    end

    assign latDone = (latCnt == LW'(ALU_LAT - 1));
    assign rspDone = (state == RESP) && bus.rsp_ready[grantIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        stateNext     = state;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        busy          = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (anyValid) begin
                    // req_ready is combinational; keep it quiet while reset is held.
                    if (rst_n) bus.req_ready = NREQ'(1) << pickIdx;
                    stateNext = EXEC;
                end
            end
            EXEC: if (latDone) stateNext = RESP;
            RESP: begin
                bus.rsp_valid = NREQ'(1) << grantIdx;
                if (rspDone) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr         <= '0;
            grantIdx      <= '0;
            latCnt        <= '0;
            bus.alu_busA  <= '0;
            bus.alu_busB  <= '0;
            bus.alu_op    <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_flags <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (anyValid) begin
                        grantIdx     <= pickIdx;
                        latCnt       <= '0;
                        bus.alu_busA <= WIDTH'(bus.req_busA >> (int'(pickIdx) * WIDTH));
                        bus.alu_busB <= WIDTH'(bus.req_busB >> (int'(pickIdx) * WIDTH));
                        bus.alu_op   <= OPW'(bus.req_op >> (int'(pickIdx) * OPW));
                    end
                end
                EXEC: begin
                    latCnt <= latCnt + LW'(1);
                    if (latDone) begin
                        bus.rsp_data  <= bus.alu_dataOut;
                        bus.rsp_flags <= bus.alu_flags;
                    end
                end
                RESP: begin
                    if (rspDone) begin
                        rrPtr <= (grantIdx == IW'(NREQ - 1)) ? '0 : grantIdx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter: a transaction-level model predicts
// grants, timing and results for an ALU_LAT=1 instance and an ALU_LAT=3 instance.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int OW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy1, busy3;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NREQ(N), .WIDTH(W), .OPW(OW)) bus1 ();
    alu_share_arbiter_if #(.NREQ(N), .WIDTH(W), .OPW(OW)) bus3 ();

    alu_share_arbiter #(.NREQ(N), .WIDTH(W), .OPW(OW), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1)
    );
    alu_share_arbiter #(.NREQ(N), .WIDTH(W), .OPW(OW), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .busy(busy3)
    );

    int nChecks = 0;
    int nFails  = 0;
    int modelPtr = 0;
    longint lastT = -1;
    logic [W-1:0]  tbA [N];
    logic [W-1:0]  tbB [N];
    logic [OW-1:0] tbOp[N];

    // Reference ALU: returns {zero, overflow, carryout, negative, result}.
    function automatic logic [35:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] wide;
        logic [31:0] r;
        logic c, v;
        wide = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin wide = {1'b0, a} - {1'b0, b}; r = wide[31:0]; c = wide[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = {31'd0, $signed(a) < $signed(b)};
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            default: r = ~a;
        endcase
        return {(r == 32'd0), v, c, r[31], r};
    endfunction

    always_comb {bus1.alu_flags, bus1.alu_dataOut} = aluFn(bus1.alu_busA, bus1.alu_busB, bus1.alu_op);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int firstFrom(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic randOps();
        for (int i = 0; i < N; i++) begin
            tbA[i]  = $urandom;
            tbB[i]  = $urandom;
            tbOp[i] = OW'($urandom_range(0, 7));
        end
    endtask

    task automatic driveReqs();
        for (int i = 0; i < N; i++) begin
            bus1.req_busA[i*W +: W]  = tbA[i];
            bus1.req_busB[i*W +: W]  = tbB[i];
            bus1.req_op[i*OW +: OW]  = tbOp[i];
        end
    endtask

    task automatic checkQuiet(input string tag);
        check({tag, "1"}, {bus1.req_ready, bus1.rsp_valid, busy1, bus1.alu_op, bus1.alu_busA,
                           bus1.alu_busB, bus1.rsp_data, bus1.rsp_flags}, '0);
        check({tag, "3"}, {bus3.req_ready, bus3.rsp_valid, busy3, bus3.alu_op, bus3.alu_busA,
                           bus3.alu_busB, bus3.rsp_data, bus3.rsp_flags}, '0);
    endtask

    // One transaction on the ALU_LAT=1 instance; called and returns at a negedge in IDLE.
    task automatic runTxn(input logic [N-1:0] validPat, input int bp, input bit keepValid);
        int w;
        logic [35:0] exp;
        logic [N-1:0] oh;
        longint t;
        driveReqs();
        bus1.req_valid = validPat;
        bus1.rsp_ready = '0;
        #1;
        w = firstFrom(validPat, modelPtr);
        if (w < 0) begin
            check("noReqReady", bus1.req_ready, '0);
            check("noReqBusy", busy1, 1'b0);
            @(negedge clk);
            return;
        end
        oh  = N'(1) << w;
        exp = aluFn(tbA[w], tbB[w], tbOp[w]);
        check("grant", bus1.req_ready, oh);
        check("idleBusy", busy1, 1'b0);
        @(posedge clk);
        t = $time;
        if (keepValid && lastT >= 0) check("issueGap", (t - lastT) / 10, 3);
        lastT = t;
        @(negedge clk);
        if (!keepValid) bus1.req_valid = N'($urandom);
        bus1.req_busA = {$urandom, $urandom, $urandom, $urandom};
        bus1.req_busB = {$urandom, $urandom, $urandom, $urandom};
        check("execReady", bus1.req_ready, '0);
        check("execRsp", bus1.rsp_valid, '0);
        check("execBusy", busy1, 1'b1);
        check("execOperands", {bus1.alu_op, bus1.alu_busA, bus1.alu_busB}, {tbOp[w], tbA[w], tbB[w]});
        @(negedge clk);
        for (int b = 0; b <= bp; b++) begin
            check("rspValid", bus1.rsp_valid, oh);
            check("rspData", bus1.rsp_data, exp[31:0]);
            check("rspFlags", bus1.rsp_flags, exp[35:32]);
            check("rspHold", {bus1.req_ready, busy1}, {N'(0), 1'b1});
            if (b < bp) bus1.rsp_ready = N'($urandom) & ~oh;
            else        bus1.rsp_ready = keepValid ? '1 : (N'($urandom) | oh);
            @(negedge clk);
        end
        modelPtr = (w + 1) % N;
        check("rspDropped", {bus1.rsp_valid, busy1}, '0);
        check("rspKept", bus1.rsp_data, exp[31:0]);
        bus1.rsp_ready = '0;
    endtask

    // One transaction on the ALU_LAT=3 instance with a fresh ALU value every cycle.
    task automatic runLat3(input int r);
        logic [31:0] a;
        logic [31:0] seen[3];
        logic [3:0]  fl[3];
        logic [N-1:0] oh;
        oh = N'(1) << r;
        a  = $urandom;
        bus3.req_busA = {$urandom, $urandom, $urandom, $urandom};
        bus3.req_busA[r*W +: W] = a;
        bus3.req_busB = {$urandom, $urandom, $urandom, $urandom};
        bus3.req_op   = 12'($urandom);
        bus3.req_valid = oh;
        #1;
        check("lat3Grant", bus3.req_ready, oh);
        @(posedge clk);
        @(negedge clk);
        bus3.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            seen[c] = $urandom;
            fl[c]   = 4'($urandom);
            bus3.alu_dataOut = seen[c];
            bus3.alu_flags   = fl[c];
            bus3.req_busA = {$urandom, $urandom, $urandom, $urandom};
            check("lat3HoldA", bus3.alu_busA, a);
            check("lat3Pending", {bus3.rsp_valid, busy3}, {N'(0), 1'b1});
            @(negedge clk);
        end
        bus3.alu_dataOut = $urandom;
        bus3.alu_flags   = 4'($urandom);
        check("lat3RspValid", bus3.rsp_valid, oh);
        check("lat3RspData", bus3.rsp_data, seen[2]);
        check("lat3RspFlags", bus3.rsp_flags, fl[2]);
        bus3.rsp_ready = oh;
        @(negedge clk);
        check("lat3Done", {bus3.rsp_valid, busy3}, '0);
        bus3.rsp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus1.req_valid = '0; bus1.req_busA = '0; bus1.req_busB = '0; bus1.req_op = '0; bus1.rsp_ready = '0;
        bus3.req_valid = '0; bus3.req_busA = '0; bus3.req_busB = '0; bus3.req_op = '0; bus3.rsp_ready = '0;
        bus3.alu_dataOut = '0; bus3.alu_flags = '0;

        // Reset held with random inputs: everything quiet.
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            randOps();
            driveReqs();
            bus1.req_valid = N'($urandom); bus1.rsp_ready = N'($urandom);
            bus3.req_valid = N'($urandom); bus3.rsp_ready = N'($urandom);
            bus3.alu_dataOut = $urandom; bus3.alu_flags = 4'($urandom);
            @(negedge clk);
            checkQuiet("reset");
        end
        bus1.req_valid = '0; bus1.rsp_ready = '0;
        bus3.req_valid = '0; bus3.rsp_ready = '0;
        rst_n = 1'b1;
        @(negedge clk);
        checkQuiet("postReset");
        modelPtr = 0;

        // All four valid, responses accepted at once: grants 0,1,2,3,0 three cycles apart.
        lastT = -1;
        for (int i = 0; i < 5; i++) begin
            randOps();
            runTxn('1, 0, 1'b1);
        end

        // Single request from r1: slt(5,9) returns 1 with clear flags.
        randOps();
        tbA[1] = 32'd5; tbB[1] = 32'd9; tbOp[1] = 3'd2;
        runTxn(4'b0010, 0, 1'b0);
        check("t2Data", bus1.rsp_data, 32'd1);
        check("t2Flags", bus1.rsp_flags, 4'd0);

        // Backpressure for five cycles.
        randOps();
        runTxn(4'b0101, 5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            randOps();
            runTxn(N'($urandom), $urandom_range(0, 3), 1'b0);
        end

        // Reset during EXEC with r2 granted, after r2 completed once so the pointer sits at 3.
        randOps();
        runTxn(4'b0100, 0, 1'b0);
        randOps();
        driveReqs();
        bus1.req_valid = 4'b0100;
        #1;
        check("t6Grant", bus1.req_ready, 4'b0100);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkQuiet("t6Abort");
        bus1.req_valid = '0;
        @(negedge clk);
        checkQuiet("t6Held");
        rst_n = 1'b1;
        modelPtr = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6NoRsp", {bus1.rsp_valid, busy1}, '0);
        end
        randOps();
        runTxn(4'b1100, 0, 1'b0);

        // Longer ALU latency instance.
        runLat3(2);
        runLat3($urandom_range(0, N - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
